// File: rtl/clint_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap/return sequencer.
//   - state encoding of the sequencer FSM
//   - mstatus bit positions touched on trap entry / mret
//   - default mcause codes and the mtvec vectored-mode encoding
package clint_trap_ctrl_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [63:0] MCAUSE_ECALL_DEF = 64'd11;
    localparam logic [63:0] MCAUSE_MTI_DEF   = {1'b1, 63'd7};

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRV_M          = 2'b11;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_MEPC,
        ST_T_MCAUSE,
        ST_T_MSTATUS,
        ST_R_MSTATUS,
        ST_REDIRECT
    } state_e;

endpackage

// File: rtl/clint_trap_ctrl_mstatus_next.sv
// Combinational mstatus update for trap entry and mret.
//   ret          : 0 = trap entry (MPIE<=MIE, MIE<=0), 1 = mret (MIE<=MPIE, MPIE<=1)
//   mstatus_cur  : live mstatus from the CSR file
//   mstatus_nxt  : value to write back; MPP is forced to M-mode in both cases
module clint_mstatus_next
    import clint_trap_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            ret,
    input  logic [XLEN-1:0] mstatus_cur,
    output logic [XLEN-1:0] mstatus_nxt
);

    always_comb begin
        mstatus_nxt = mstatus_cur;
        mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
        if (ret) begin
            mstatus_nxt[MSTATUS_MIE]  = mstatus_cur[MSTATUS_MPIE];
            mstatus_nxt[MSTATUS_MPIE] = 1'b1;
        end else begin
            mstatus_nxt[MSTATUS_MPIE] = mstatus_cur[MSTATUS_MIE];
            mstatus_nxt[MSTATUS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/clint_trap_ctrl.sv
// Trap/return sequencer for the machine-mode CSR file.
// At an instruction boundary it accepts ecall, an enabled+pending machine
// timer interrupt, or mret (in that priority), writes mepc/mcause/mstatus
// through the CSR file's clint-side ports one per cycle, stalls the pipe
// throughout, and finishes with a single redirect pulse.
// Ports:
//   inst_valid_i/inst_pc_i/ecall_i/mret_i : commit-stage instruction info
//   cpu_csr_wen_i     : CPU CSR write in flight; clint writes hold while high
//   global_int_en_i/mtime_int_en_i/mtime_int_pend_i : MIE, MTIE, MTIP
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i : live CSR values
//   clint_*_wen_o/clint_*_wdata_o : CSR-file write ports
//   stall_o           : hold fetch/decode/execute
//   redirect_valid_o/redirect_pc_o : one-cycle redirect + flush
module clint_trap_ctrl
    import clint_trap_ctrl_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] MCAUSE_ECALL = MCAUSE_ECALL_DEF,
    parameter logic [XLEN-1:0] MCAUSE_MTI   = MCAUSE_MTI_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_pc_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            cpu_csr_wen_i,
    input  logic            global_int_en_i,
    input  logic            mtime_int_en_i,
    input  logic            mtime_int_pend_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    output logic            clint_mepc_wen_o,
    output logic [XLEN-1:0] clint_mepc_wdata_o,
    output logic            clint_mcause_wen_o,
    output logic [XLEN-1:0] clint_mcause_wdata_o,
    output logic            clint_mstatus_wen_o,
    output logic [XLEN-1:0] clint_mstatus_wdata_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, cause_q;
    logic            is_int_q, is_ret_q;

    logic            int_take, accept, trap_take;
    logic [XLEN-1:0] mstatus_nxt, vec_base;

    assign int_take  = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    assign trap_take = ecall_i | int_take;
    assign accept    = (state_q == ST_IDLE) & inst_valid_i & (trap_take | mret_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            is_int_q <= 1'b0;
            is_ret_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q     <= inst_pc_i;
                cause_q  <= ecall_i ? MCAUSE_ECALL : (int_take ? MCAUSE_MTI : '0);
                is_int_q <= ~ecall_i & int_take;
                is_ret_q <= ~trap_take;
            end
        end
    end

    // Write states only move on when the CPU is not writing a CSR, since the
    // CSR file drops clint writes in that cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (inst_valid_i) begin
                    if (trap_take)   state_d = ST_T_MEPC;
                    else if (mret_i) state_d = ST_R_MSTATUS;
                end
            end
            ST_T_MEPC:    if (!cpu_csr_wen_i) state_d = ST_T_MCAUSE;
            ST_T_MCAUSE:  if (!cpu_csr_wen_i) state_d = ST_T_MSTATUS;
            ST_T_MSTATUS: if (!cpu_csr_wen_i) state_d = ST_REDIRECT;
            ST_R_MSTATUS: if (!cpu_csr_wen_i) state_d = ST_REDIRECT;
            ST_REDIRECT:  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    clint_mstatus_next #(.XLEN(XLEN)) u_mstatus_next (
        .ret         (state_q == ST_R_MSTATUS),
        .mstatus_cur (csr_mstatus_i),
        .mstatus_nxt (mstatus_nxt)
    );

    assign clint_mepc_wen_o      = (state_q == ST_T_MEPC);
    assign clint_mepc_wdata_o    = clint_mepc_wen_o ? pc_q : '0;
    assign clint_mcause_wen_o    = (state_q == ST_T_MCAUSE);
    assign clint_mcause_wdata_o  = clint_mcause_wen_o ? cause_q : '0;
    assign clint_mstatus_wen_o   = (state_q == ST_T_MSTATUS) | (state_q == ST_R_MSTATUS);
    assign clint_mstatus_wdata_o = clint_mstatus_wen_o ? mstatus_nxt : '0;

    assign stall_o          = (state_q != ST_IDLE) | accept;
    assign redirect_valid_o = (state_q == ST_REDIRECT);

    // Vectored mode applies to interrupts only: base + 4*cause (cause MSB dropped).
    assign vec_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
    always_comb begin
        redirect_pc_o = '0;
        if (redirect_valid_o) begin
            if (is_ret_q)
                redirect_pc_o = csr_mepc_i;
            else if (is_int_q && csr_mtvec_i[1:0] == MTVEC_VECTORED)
                redirect_pc_o = vec_base + {cause_q[XLEN-3:0], 2'b00};
            else
                redirect_pc_o = vec_base;
        end
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
module tb_clint_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid_i, ecall_i, mret_i, cpu_csr_wen_i;
    logic        global_int_en_i, mtime_int_en_i, mtime_int_pend_i;
    logic [63:0] inst_pc_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        clint_mepc_wen_o, clint_mcause_wen_o, clint_mstatus_wen_o;
    logic [63:0] clint_mepc_wdata_o, clint_mcause_wdata_o, clint_mstatus_wdata_o;
    logic        stall_o, redirect_valid_o;
    logic [63:0] redirect_pc_o;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    clint_trap_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .inst_valid_i          (inst_valid_i),
        .inst_pc_i             (inst_pc_i),
        .ecall_i               (ecall_i),
        .mret_i                (mret_i),
        .cpu_csr_wen_i         (cpu_csr_wen_i),
        .global_int_en_i       (global_int_en_i),
        .mtime_int_en_i        (mtime_int_en_i),
        .mtime_int_pend_i      (mtime_int_pend_i),
        .csr_mtvec_i           (csr_mtvec_i),
        .csr_mepc_i            (csr_mepc_i),
        .csr_mstatus_i         (csr_mstatus_i),
        .clint_mepc_wen_o      (clint_mepc_wen_o),
        .clint_mepc_wdata_o    (clint_mepc_wdata_o),
        .clint_mcause_wen_o    (clint_mcause_wen_o),
        .clint_mcause_wdata_o  (clint_mcause_wdata_o),
        .clint_mstatus_wen_o   (clint_mstatus_wen_o),
        .clint_mstatus_wdata_o (clint_mstatus_wdata_o),
        .stall_o               (stall_o),
        .redirect_valid_o      (redirect_valid_o),
        .redirect_pc_o         (redirect_pc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference mstatus rules, written as bit arithmetic on the architectural fields.
    function automatic logic [63:0] trap_ms(input logic [63:0] s);
        logic [63:0] r;
        r = (s & ~64'h1888) | 64'h1800;
        if (s[3]) r = r | 64'h80;
        return r;
    endfunction

    function automatic logic [63:0] ret_ms(input logic [63:0] s);
        logic [63:0] r;
        r = (s & ~64'h1888) | 64'h1880;
        if (s[7]) r = r | 64'h8;
        return r;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".mepc_wen"},    64'(clint_mepc_wen_o), 64'd0);
        chk({tag, ".mcause_wen"},  64'(clint_mcause_wen_o), 64'd0);
        chk({tag, ".mstatus_wen"}, 64'(clint_mstatus_wen_o), 64'd0);
        chk({tag, ".redirect"},    64'(redirect_valid_o), 64'd0);
    endtask

    // One event at an instruction boundary followed by its full sequence.
    // Expected writes are kept as a queue (0 mepc, 1 mcause, 2 trap mstatus,
    // 3 mret mstatus); the head retires on any cycle the CPU is not writing.
    // blk: 0 never block, 1 random blocking, 2 block 3 cycles while mcause is due.
    task automatic run_event(input bit ec, input bit mr, input bit gie, input bit mtie,
                             input bit mtip, input logic [63:0] pc, input logic [63:0] ms,
                             input logic [63:0] tvec, input logic [63:0] epc,
                             input int blk, input bit rnd, input int exp_lat);
        int          q[$];
        bit          take_int, trap, done;
        int          cyc, held;
        logic [63:0] cause, exp_pc;
        take_int = gie & mtie & mtip;
        trap     = ec | take_int;
        cause    = ec ? 64'd11 : 64'h8000_0000_0000_0007;
        if (trap)    q = '{0, 1, 2};
        else if (mr) q = '{3};

        inst_valid_i = 1'b1; ecall_i = ec; mret_i = mr; cpu_csr_wen_i = 1'b0;
        global_int_en_i = gie; mtime_int_en_i = mtie; mtime_int_pend_i = mtip;
        inst_pc_i = pc; csr_mstatus_i = ms; csr_mtvec_i = tvec; csr_mepc_i = epc;
        @(negedge clk);
        chk("accept.stall", 64'(stall_o), 64'(trap | mr));
        chk_quiet("accept");
        @(posedge clk); #1;

        cyc = 1; held = 0; done = (q.size() == 0);
        while (!done && cyc < 40) begin
            inst_valid_i = 1'($urandom_range(0, 1));
            ecall_i      = 1'($urandom_range(0, 1));
            mret_i       = 1'($urandom_range(0, 1));
            global_int_en_i  = 1'($urandom_range(0, 1));
            mtime_int_en_i   = 1'($urandom_range(0, 1));
            mtime_int_pend_i = 1'($urandom_range(0, 1));
            inst_pc_i    = {$urandom(), $urandom()};
            cpu_csr_wen_i = 1'b0;
            if (blk == 1) cpu_csr_wen_i = ($urandom_range(0, 2) == 0);
            else if (blk == 2 && q.size() > 0 && q[0] == 1 && held < 3) begin
                cpu_csr_wen_i = 1'b1; held++;
            end
            if (rnd) begin
                csr_mstatus_i = {$urandom(), $urandom()};
                csr_mtvec_i   = {$urandom(), $urandom()};
                csr_mepc_i    = {$urandom(), $urandom()};
            end
            @(negedge clk);
            chk("seq.stall", 64'(stall_o), 64'd1);
            chk("seq.mepc_wen",    64'(clint_mepc_wen_o),    64'(q.size() > 0 && q[0] == 0));
            chk("seq.mcause_wen",  64'(clint_mcause_wen_o),  64'(q.size() > 0 && q[0] == 1));
            chk("seq.mstatus_wen", 64'(clint_mstatus_wen_o), 64'(q.size() > 0 && q[0] >= 2));
            chk("seq.redirect",    64'(redirect_valid_o),    64'(q.size() == 0));
            if (q.size() > 0) begin
                case (q[0])
                    0: chk("mepc_wdata", clint_mepc_wdata_o, pc);
                    1: chk("mcause_wdata", clint_mcause_wdata_o, cause);
                    2: chk("mstatus_trap_wdata", clint_mstatus_wdata_o, trap_ms(csr_mstatus_i));
                    default: chk("mstatus_ret_wdata", clint_mstatus_wdata_o, ret_ms(csr_mstatus_i));
                endcase
            end else begin
                if (!trap) exp_pc = csr_mepc_i;
                else if (!ec && csr_mtvec_i[1:0] == 2'b01)
                    exp_pc = (csr_mtvec_i & ~64'h3) + 64'd4 * (cause & 64'h7FFF_FFFF_FFFF_FFFF);
                else exp_pc = csr_mtvec_i & ~64'h3;
                chk("redirect_pc", redirect_pc_o, exp_pc);
                if (exp_lat >= 0) chk("latency", 64'(cyc), 64'(exp_lat));
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (q.size() > 0 && !cpu_csr_wen_i) void'(q.pop_front());
            cyc++;
        end
        chk("sequence_complete", 64'(done), 64'd1);

        inst_valid_i = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; cpu_csr_wen_i = 1'b0;
        @(negedge clk);
        chk("idle.stall", 64'(stall_o), 64'd0);
        chk_quiet("idle");
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        inst_valid_i = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; cpu_csr_wen_i = 1'b0;
        global_int_en_i = 1'b0; mtime_int_en_i = 1'b0; mtime_int_pend_i = 1'b0;
        inst_pc_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;
        #12;
        chk("reset.stall", 64'(stall_o), 64'd0);
        chk_quiet("reset");
        chk("reset.redirect_pc", redirect_pc_o, 64'd0);
        chk("reset.mepc_wdata", clint_mepc_wdata_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ecall, direct-mode mtvec
        run_event(1, 0, 0, 0, 0, 64'h8000_0010, 64'h1808, 64'h8000_1000, 64'h0, 0, 0, 4);
        // timer interrupt, vectored mtvec
        run_event(0, 0, 1, 1, 1, 64'h8000_0020, 64'h1808, 64'h8000_1001, 64'h0, 0, 0, 4);
        // mret
        run_event(0, 1, 0, 0, 0, 64'h8000_0030, 64'h1880, 64'h8000_1000, 64'h8000_0024, 0, 0, 2);
        // CPU CSR write holds mcause for 3 cycles
        run_event(1, 0, 0, 0, 0, 64'h8000_0040, 64'h1808, 64'h8000_1000, 64'h0, 2, 0, 7);
        // ecall wins over a pending enabled timer, even with vectored mtvec
        run_event(1, 0, 1, 1, 1, 64'h8000_0050, 64'h1808, 64'h8000_1001, 64'h0, 0, 0, 4);
        // MIE now clear: the still-pending timer is not taken
        run_event(0, 0, 0, 1, 1, 64'h8000_0054, 64'h1880, 64'h8000_1001, 64'h0, 0, 0, -1);

        // Async reset in T_MCAUSE aborts the sequence
        inst_valid_i = 1'b1; ecall_i = 1'b1; inst_pc_i = 64'h8000_0060;
        csr_mtvec_i = 64'h8000_1000; csr_mstatus_i = 64'h1808;
        @(posedge clk); #1;
        inst_valid_i = 1'b0; ecall_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset.mcause_wen", 64'(clint_mcause_wen_o), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset.stall", 64'(stall_o), 64'd0);
        chk_quiet("midreset");
        chk("midreset.mcause_wdata", clint_mcause_wdata_o, 64'd0);
        chk("midreset.mstatus_wdata", clint_mstatus_wdata_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postreset.stall", 64'(stall_o), 64'd0);
            chk("postreset.redirect", 64'(redirect_valid_o), 64'd0);
        end
        @(posedge clk); #1;

        // Randomized events with random blocking and live CSR values
        for (int n = 0; n < 30; n++) begin
            run_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                      {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      {$urandom(), $urandom()}, 1, 1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
- Trap/return sequencer for the machine-mode CSR file.
- Detects ecall, mret and the enabled/pending machine timer interrupt at an instruction boundary.
- Drives the CSR file's clint-side write ports (mepc, mcause, mstatus) as a multi-cycle sequence, stalls the pipeline meanwhile, then issues one redirect/flush to the trap vector or to mepc.
- Sits between the execute/commit stage, the CSR file and the PC-generation logic.

Parameters:
- XLEN, 64, data/address width
- MCAUSE_ECALL, 64'd11, cause code for environment call from M-mode
- MCAUSE_MTI, {1'b1,63'd7}, cause code for machine timer interrupt

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid_i  in  1  commit-stage instruction valid (instruction boundary)
- inst_pc_i  in  XLEN  PC of that instruction
- ecall_i  in  1  instruction is ecall (qualified by inst_valid_i)
- mret_i  in  1  instruction is mret (qualified by inst_valid_i)
- cpu_csr_wen_i  in  1  CPU CSR-instruction write this cycle; CSR file ignores clint writes while high
- global_int_en_i  in  1  mstatus.MIE
- mtime_int_en_i  in  1  mie.MTIE
- mtime_int_pend_i  in  1  mip.MTIP
- csr_mtvec_i  in  XLEN  current mtvec
- csr_mepc_i  in  XLEN  current mepc
- csr_mstatus_i  in  XLEN  current mstatus
- clint_mepc_wen_o  out  1  mepc write enable
- clint_mepc_wdata_o  out  XLEN  mepc write data
- clint_mcause_wen_o  out  1  mcause write enable
- clint_mcause_wdata_o  out  XLEN  mcause write data
- clint_mstatus_wen_o  out  1  mstatus write enable
- clint_mstatus_wdata_o  out  XLEN  mstatus write data
- stall_o  out  1  hold fetch/decode/execute
- redirect_valid_o  out  1  one-cycle redirect + flush pulse
- redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0): state IDLE; all wen, stall_o and redirect_valid_o = 0; all data outputs and latches = 0. Reset mid-sequence aborts it; no partial sequence resumes.
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, REDIRECT.
- IDLE accepts an event only when inst_valid_i=1. Priority: ecall > timer interrupt > mret.
  - Timer interrupt condition: global_int_en_i & mtime_int_en_i & mtime_int_pend_i.
  - Accept latches pc = inst_pc_i, cause, and is_int.
  - Trap (ecall or interrupt) -> T_MEPC. mret -> R_MSTATUS.
  - stall_o is asserted combinationally in the accept cycle.
- T_MEPC: mepc_wen=1, wdata = latched pc. Interrupts are taken before the instruction executes, so mepc = its own pc for both causes.
- T_MCAUSE: mcause_wen=1, wdata = latched cause.
- T_MSTATUS: mstatus_wen=1; wdata = csr_mstatus_i with MPIE[7] <= MIE[3], MIE[3] <= 0, MPP[12:11] <= 2'b11, other bits unchanged.
- R_MSTATUS: mstatus_wen=1; wdata = csr_mstatus_i with MIE[3] <= MPIE[7], MPIE[7] <= 1, MPP[12:11] <= 2'b11.
- Write-state advance rule:
  - Advance only on a cycle where cpu_csr_wen_i=0.
  - If cpu_csr_wen_i=1, hold the state and keep wen/wdata asserted; the write lands on the first cycle cpu_csr_wen_i=0.
  - mstatus wdata is recomputed from the live csr_mstatus_i on every held cycle.
- Sequence order: T_MEPC -> T_MCAUSE -> T_MSTATUS -> REDIRECT; R_MSTATUS -> REDIRECT.
- REDIRECT: redirect_valid_o=1 for exactly one cycle, stall_o=1, then -> IDLE.
  - Trap target: mtvec[1:0]=2'b01 and is_int gives {mtvec[63:2],2'b00} + 4*cause[62:0]; otherwise {mtvec[63:2],2'b00}. mtvec is sampled in REDIRECT.
  - mret target: csr_mepc_i sampled in REDIRECT.
- Latency without blocking:
  - Trap: 4 cycles accept->redirect, 3 write cycles.
  - mret: 2 cycles accept->redirect.
- stall_o is high in every non-IDLE state. Events presented while not IDLE are ignored; upstream holds the instruction under stall_o.
- After a trap, the timer interrupt is masked because MIE=0. No re-entry occurs until software re-enables it.
- Outputs are registered where practical; wen/wdata are decoded from state plus latched data only (no combinational path from inst_* to wen).

Decomposition:
- Shared defines: state encoding, mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), mcause constants, mtvec mode encoding.
- One natural sub-module: clint_mstatus_next, a combinational trap/return mstatus update selected by a mode bit.

Test Plan:
- ecall at pc 0x8000_0010, mtvec 0x8000_1000, mstatus 0x1808 -> mepc=0x8000_0010, mcause=11, mstatus=0x1880, redirect 0x8000_1000 four cycles after accept.
- MIE=1, MTIE=1, MTIP=1 at pc 0x8000_0020 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0020; with mtvec=0x8000_1001 -> redirect 0x8000_101C.
- mret with mepc 0x8000_0024, mstatus 0x1880 -> mstatus=0x1888, redirect 0x8000_0024 two cycles after accept.
- cpu_csr_wen_i high for 3 cycles during T_MCAUSE -> mcause_wen held, state frozen, redirect delayed by exactly 3 cycles, final values correct.
- ecall and pending enabled timer in the same cycle -> mcause=11 only; interrupt not taken afterwards because MIE=0. Interrupt with MIE=0 -> no sequence, stall_o=0.
- rst_n deasserted asynchronously in T_MCAUSE -> all outputs 0 immediately, IDLE, no redirect.
